// File: rtl/rhythm_core.sv
// rhythm_core: scrolls a ROWS x LANES note map toward the judge row (row 0),
// judges lane hits with a perfect/good window and tracks score, combo, HP and speed.
`timescale 1ns/1ps
module rhythm_core #(
  parameter int LANES       = 4,
  parameter int ROWS        = 8,
  parameter int BASE_PERIOD = 25_000_000,
  parameter int PERIOD_MIN  = 5_000_000,
  parameter int PERIOD_STEP = 100_000,
  parameter int PERF_PTS    = 10,
  parameter int GOOD_PTS    = 5,
  parameter int HP_MAX      = 10,
  parameter int MISS_DMG    = 1,
  parameter int OVER_CYCLES = 150_000_000
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  input  logic                          i_Start,
  input  logic                          i_Pause,
  input  logic [LANES-1:0]              i_Hit,
  input  logic [LANES+3:0]              i_Rand,
  input  logic [3:0]                    i_Density,
  input  logic [1:0]                    i_Speed_Opt,
  output logic [ROWS*LANES-1:0]         o_Map,
  output logic [15:0]                   o_Score,
  output logic [15:0]                   o_High_Score,
  output logic [7:0]                    o_Combo,
  output logic [7:0]                    o_Max_Combo,
  output logic [$clog2(HP_MAX+1)-1:0]   o_HP,
  output logic [1:0]                    o_State,
  output logic                          o_Judge_Valid,
  output logic [1:0]                    o_Judge
);
  localparam int MW = ROWS*LANES;
  localparam int HW = $clog2(HP_MAX+1);
  localparam int CW = $clog2(BASE_PERIOD+1);
  localparam int OW = $clog2(OVER_CYCLES+1);
  localparam logic [CW-1:0] BASE_P    = CW'(BASE_PERIOD);
  localparam logic [OW-1:0] OVER_LAST = OW'(OVER_CYCLES-1);
  localparam logic [HW-1:0] HP_FULL   = HW'(HP_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   map_q, map_d;
  logic [15:0]     score_q, score_d, high_q, high_d;
  logic [7:0]      combo_q, combo_d, maxc_q, maxc_d;
  logic [HW-1:0]   hp_q, hp_d;
  logic [CW-1:0]   period_q, period_d, cnt_q, cnt_d;
  logic [OW-1:0]   ovc_q, ovc_d;
  logic            jv_q, jv_d;
  logic [1:0]      j_q, j_d;

  logic [MW-1:0]    map_hit;
  logic [LANES-1:0] new_row;
  logic [CW-1:0]    quarter;
  logic             tick, in_window;
  logic [4:0]       n_perf, n_good, n_miss;
  logic [31:0]      score_sum, combo_sum, dmg;
  logic [7:0]       combo_new;

  function automatic logic [15:0] sat_u16(input logic [31:0] v);
    return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
  endfunction

  function automatic logic [7:0] sat_u8(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

  function automatic logic [HW-1:0] sub_floor0(input logic [HW-1:0] hp, input logic [31:0] d);
    return (d >= 32'(hp)) ? '0 : HW'(32'(hp) - d);
  endfunction

  function automatic logic [CW-1:0] next_period(input logic [CW-1:0] p);
    return (32'(p) >= 32'(PERIOD_MIN) + 32'(PERIOD_STEP)) ?
           CW'(32'(p) - 32'(PERIOD_STEP)) : CW'(PERIOD_MIN);
  endfunction

  function automatic logic [CW-1:0] idle_period(input logic [1:0] opt);
    case (opt)
      2'b01:   return BASE_P >> 1;
      2'b10:   return BASE_P >> 2;
      default: return BASE_P;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    map_d     = map_q;
    score_d   = score_q;
    high_d    = high_q;
    combo_d   = combo_q;
    maxc_d    = maxc_q;
    hp_d      = hp_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    ovc_d     = ovc_q;
    jv_d      = 1'b0;
    j_d       = 2'd0;
    map_hit   = map_q;
    n_perf    = '0;
    n_good    = '0;
    n_miss    = '0;
    score_sum = '0;
    combo_sum = '0;
    dmg       = '0;
    combo_new = combo_q;
    quarter   = period_q >> 2;
    in_window = (cnt_q >= quarter) && (cnt_q < period_q - quarter);
    // >= rather than == so a shortened period can never strand the counter past it
    tick      = (cnt_q >= period_q - CW'(1));
    new_row   = (i_Rand[3:0] < i_Density) ? i_Rand[LANES+3:4] : '0;

    case (state_q)
      S_IDLE: begin
        period_d = idle_period(i_Speed_Opt);
        if (i_Start) begin
          state_d = S_PLAY;
          score_d = '0;
          combo_d = '0;
          map_d   = '0;
          cnt_d   = '0;
          hp_d    = HP_FULL;
        end
      end
      S_PLAY: begin
        if (hp_q == '0) begin
          state_d = S_OVER;
          ovc_d   = '0;
          if (score_q > high_q) high_d = score_q;
        end else if (i_Pause) begin
          state_d = S_PAUSE;
        end else begin
          // hits are judged against row 0 before any scroll in this cycle
          for (int l = 0; l < LANES; l++) begin
            if (i_Hit[l]) begin
              if (map_q[l]) begin
                map_hit[l] = 1'b0;
                if (in_window) n_perf = n_perf + 5'd1;
                else           n_good = n_good + 5'd1;
              end else begin
                n_miss = n_miss + 5'd1;
              end
            end
          end
          if (tick) begin
            cnt_d = '0;
            for (int l = 0; l < LANES; l++) begin
              if (map_hit[l]) n_miss = n_miss + 5'd1;
            end
            map_d = {new_row, map_hit[MW-1:LANES]};
          end else begin
            cnt_d = cnt_q + CW'(1);
            map_d = map_hit;
          end
          score_sum = 32'(score_q) + 32'(PERF_PTS) * 32'(n_perf) + 32'(GOOD_PTS) * 32'(n_good);
          score_d   = sat_u16(score_sum);
          combo_sum = 32'(combo_q) + 32'(n_perf) + 32'(n_good);
          combo_new = (n_miss != '0) ? 8'd0 : sat_u8(combo_sum);
          combo_d   = combo_new;
          if (combo_new > maxc_q) maxc_d = combo_new;
          dmg  = 32'(MISS_DMG) * 32'(n_miss);
          hp_d = sub_floor0(hp_q, dmg);
          if ((n_perf + n_good) != '0) period_d = next_period(period_q);
          if (n_miss != '0) begin
            jv_d = 1'b1;
            j_d  = 2'd3;
          end else if (n_good != '0) begin
            jv_d = 1'b1;
            j_d  = 2'd2;
          end else if (n_perf != '0) begin
            jv_d = 1'b1;
            j_d  = 2'd1;
          end
        end
      end
      S_PAUSE: begin
        if (!i_Pause) state_d = S_PLAY;
      end
      S_OVER: begin
        if (ovc_q == OVER_LAST) state_d = S_IDLE;
        else                    ovc_d   = ovc_q + OW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q  <= S_IDLE;
      map_q    <= '0;
      score_q  <= '0;
      high_q   <= '0;
      combo_q  <= '0;
      maxc_q   <= '0;
      hp_q     <= HP_FULL;
      period_q <= BASE_P;
      cnt_q    <= '0;
      ovc_q    <= '0;
      jv_q     <= 1'b0;
      j_q      <= 2'd0;
    end else begin
      state_q  <= state_d;
      map_q    <= map_d;
      score_q  <= score_d;
      high_q   <= high_d;
      combo_q  <= combo_d;
      maxc_q   <= maxc_d;
      hp_q     <= hp_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      ovc_q    <= ovc_d;
      jv_q     <= jv_d;
      j_q      <= j_d;
    end
  end

  assign o_Map         = map_q;
  assign o_Score       = score_q;
  assign o_High_Score  = high_q;
  assign o_Combo       = combo_q;
  assign o_Max_Combo   = maxc_q;
  assign o_HP          = hp_q;
  assign o_State       = state_q;
  assign o_Judge_Valid = jv_q;
  assign o_Judge       = j_q;

endmodule

// File: tb/tb_rhythm_core.sv
// Bench for rhythm_core: a cycle model pushes expected outputs per driven cycle,
// popped and compared after the clock edge, plus directed checks of key scenarios.
`timescale 1ns/1ps
module tb_rhythm_core;
  localparam int LANES = 4, ROWS = 4, BASE = 16, PMIN = 4, PSTEP = 2;
  localparam int HPM = 3, OVER = 20, PERF = 10, GOOD = 5, DMG = 1;
  localparam int MW = ROWS*LANES;

  logic             clk = 1'b0, rst = 1'b1, start = 1'b0, pause = 1'b0;
  logic [LANES-1:0] hit = '0;
  logic [LANES+3:0] rnd = '0;
  logic [3:0]       dens = '0;
  logic [1:0]       spd = '0;
  logic [MW-1:0]    o_map;
  logic [15:0]      o_score, o_high;
  logic [7:0]       o_combo, o_maxc;
  logic [1:0]       o_hp, o_state, o_j;
  logic             o_jv;

  rhythm_core #(
    .LANES(LANES), .ROWS(ROWS), .BASE_PERIOD(BASE), .PERIOD_MIN(PMIN),
    .PERIOD_STEP(PSTEP), .PERF_PTS(PERF), .GOOD_PTS(GOOD), .HP_MAX(HPM),
    .MISS_DMG(DMG), .OVER_CYCLES(OVER)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Pause(pause), .i_Hit(hit),
    .i_Rand(rnd), .i_Density(dens), .i_Speed_Opt(spd), .o_Map(o_map),
    .o_Score(o_score), .o_High_Score(o_high), .o_Combo(o_combo),
    .o_Max_Combo(o_maxc), .o_HP(o_hp), .o_State(o_state),
    .o_Judge_Valid(o_jv), .o_Judge(o_j)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MW-1:0] map;
    int score, high, combo, maxc, hp, state, jv, j;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0, n_err = 0;

  int m_state, m_score, m_high, m_combo, m_maxc, m_hp, m_period, m_cnt, m_ovc, m_jv, m_j;
  logic [LANES-1:0] m_map [ROWS];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_score = 0; m_high = 0; m_combo = 0; m_maxc = 0;
    m_hp = HPM; m_period = BASE; m_cnt = 0; m_ovc = 0; m_jv = 0; m_j = 0;
    for (int r = 0; r < ROWS; r++) m_map[r] = '0;
  endtask

  task automatic model_step();
    int np, ng, nm, q;
    np = 0; ng = 0; nm = 0;
    m_jv = 0; m_j = 0;
    case (m_state)
      0: begin
        m_period = (spd == 2'b01) ? BASE / 2 : (spd == 2'b10) ? BASE / 4 : BASE;
        if (start) begin
          m_state = 1; m_score = 0; m_combo = 0; m_cnt = 0; m_hp = HPM;
          for (int r = 0; r < ROWS; r++) m_map[r] = '0;
        end
      end
      1: begin
        if (m_hp == 0) begin
          m_state = 3; m_ovc = 0;
          if (m_score > m_high) m_high = m_score;
        end else if (pause) begin
          m_state = 2;
        end else begin
          q = m_period / 4;
          for (int l = 0; l < LANES; l++) begin
            if (hit[l]) begin
              if (m_map[0][l]) begin
                m_map[0][l] = 1'b0;
                if (m_cnt >= q && m_cnt < m_period - q) np++;
                else ng++;
              end else nm++;
            end
          end
          if (m_cnt == m_period - 1) begin
            m_cnt = 0;
            for (int l = 0; l < LANES; l++) nm += int'(m_map[0][l]);
            for (int r = 0; r < ROWS - 1; r++) m_map[r] = m_map[r+1];
            m_map[ROWS-1] = (rnd[3:0] < dens) ? rnd[LANES+3:4] : '0;
          end else m_cnt++;
          m_score += PERF * np + GOOD * ng;
          if (m_score > 65535) m_score = 65535;
          if (nm > 0) m_combo = 0;
          else begin
            m_combo += np + ng;
            if (m_combo > 255) m_combo = 255;
          end
          if (m_combo > m_maxc) m_maxc = m_combo;
          m_hp -= DMG * nm;
          if (m_hp < 0) m_hp = 0;
          if (np + ng > 0) begin
            m_period -= PSTEP;
            if (m_period < PMIN) m_period = PMIN;
          end
          if (nm > 0) begin m_jv = 1; m_j = 3; end
          else if (ng > 0) begin m_jv = 1; m_j = 2; end
          else if (np > 0) begin m_jv = 1; m_j = 1; end
        end
      end
      2: if (!pause) m_state = 1;
      default: begin
        if (m_ovc == OVER - 1) m_state = 0;
        else m_ovc++;
      end
    endcase
  endtask

  function automatic exp_t snap();
    exp_t e;
    for (int r = 0; r < ROWS; r++) e.map[r*LANES +: LANES] = m_map[r];
    e.score = m_score; e.high = m_high; e.combo = m_combo; e.maxc = m_maxc;
    e.hp = m_hp; e.state = m_state; e.jv = m_jv; e.j = m_j;
    return e;
  endfunction

  task automatic step();
    exp_t e;
    model_step();
    sb.push_back(snap());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("map", o_map, e.map);
    chk("score", o_score, e.score);
    chk("high", o_high, e.high);
    chk("combo", o_combo, e.combo);
    chk("maxc", o_maxc, e.maxc);
    chk("hp", o_hp, e.hp);
    chk("state", o_state, e.state);
    chk("jv", o_jv, e.jv);
    chk("judge", o_j, e.j);
  endtask

  initial begin
    int k;
    int cnt_at_pause;
    model_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_state", o_state, 0);
    chk("rst_hp", o_hp, 3);
    chk("rst_map", o_map, 0);
    chk("rst_score", o_score, 0);
    chk("rst_jv", o_jv, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();

    // first row scrolls in and down to the judge row
    spd = 2'b00; rnd = 8'h50; dens = 4'd15; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) step();
    chk("top_row", o_map[15:12], 4'b0101);
    dens = 4'd0;
    for (int i = 0; i < 48; i++) step();
    chk("judge_row", o_map, 16'h0005);

    // simultaneous perfect hits
    k = 0;
    while (m_cnt != 8 && k < 40) begin step(); k++; end
    hit = 4'b0101;
    step();
    hit = '0;
    chk("perf_score", o_score, 20);
    chk("perf_combo", o_combo, 2);
    chk("perf_jv", o_jv, 1);
    chk("perf_code", o_j, 1);
    chk("perf_map", o_map, 0);

    // next scroll arrives after the shortened period of 14
    rnd = 8'h20; dens = 4'd15;
    k = 0;
    while (o_map[15:12] == 4'd0 && k < 50) begin step(); k++; end
    chk("period14_steps", k, 5);
    dens = 4'd0;
    k = 0;
    while (o_map[3:0] == 4'd0 && k < 60) begin step(); k++; end
    chk("row0_wait", (k < 60), 1);
    step();
    step();
    hit = 4'b1010;
    step();
    hit = '0;
    chk("good_ghost_score", o_score, 25);
    chk("good_ghost_code", o_j, 3);
    chk("good_ghost_combo", o_combo, 0);
    chk("good_ghost_hp", o_hp, 2);
    chk("good_ghost_maxc", o_maxc, 2);

    // two notes drop unhit and drain the remaining HP
    rnd = 8'h30; dens = 4'd15;
    k = 0;
    while (o_map[15:12] == 4'd0 && k < 50) begin step(); k++; end
    dens = 4'd0;
    k = 0;
    while (o_map[3:0] == 4'd0 && k < 60) begin step(); k++; end
    k = 0;
    while (o_hp == 2'd2 && k < 30) begin step(); k++; end
    chk("drop_hp", o_hp, 0);
    chk("drop_map", o_map, 0);
    step();
    chk("over_state", o_state, 3);
    chk("over_high", o_high, 25);
    for (int i = 0; i < 19; i++) begin
      start = (i == 5);
      hit = LANES'($urandom_range(0, 15));
      step();
    end
    start = 1'b0;
    hit = '0;
    chk("over_hold", o_state, 3);
    step();
    chk("over_exit", o_state, 0);

    // pause freezes scrolling; release resumes the same count
    spd = 2'b01; rnd = 8'h50; dens = 4'd15;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_hp", o_hp, 3);
    chk("restart_score", o_score, 0);
    chk("keep_high", o_high, 25);
    chk("keep_maxc", o_maxc, 2);
    for (int i = 0; i < 12; i++) step();
    cnt_at_pause = m_cnt;
    pause = 1'b1;
    hit = 4'b1111;
    step();
    hit = '0;
    chk("pause_state", o_state, 2);
    chk("pause_jv", o_jv, 0);
    for (int i = 0; i < 9; i++) begin
      start = (i == 3);
      hit = (i == 4) ? 4'b1111 : 4'b0000;
      step();
    end
    start = 1'b0;
    hit = '0;
    chk("pause_hold", o_state, 2);
    chk("pause_map", o_map, 16'h5000);
    pause = 1'b0;
    step();
    chk("resume_state", o_state, 1);
    k = 0;
    while (o_map[11:8] == 4'd0 && k < 20) begin step(); k++; end
    chk("resume_steps", k, 8 - cnt_at_pause);
    for (int i = 0; i < 3; i++) step();

    // asynchronous reset in the middle of play
    rst = 1'b0;
    #1;
    chk("arst_state", o_state, 0);
    chk("arst_map", o_map, 0);
    chk("arst_score", o_score, 0);
    chk("arst_high", o_high, 0);
    chk("arst_maxc", o_maxc, 0);
    chk("arst_hp", o_hp, 3);
    model_reset();
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rhythm_core.md
# rhythm_core

Parametrised successor of the rhythm-game engine: scrolls a ROWS×LANES note map toward a judge row, scores button hits with a two-level timing window, tracks combo, HP, high score and max combo, and adapts scroll speed. It sits between the button pulse synchroniser/LFSR and the dot-matrix, FND and sound drivers. Unlike the fixed 4-lane engine, it supports any lane count, accumulates simultaneous hits, has numeric HP, a pause state and density-controlled note generation.

## Interface
- LANES, 4, number of lanes (2..8)
- ROWS, 8, map depth in rows (>=2)
- BASE_PERIOD, 25_000_000, clocks per scroll step at 1x
- PERIOD_MIN, 5_000_000, fastest scroll period
- PERIOD_STEP, 100_000, period decrement per scoring cycle
- PERF_PTS, 10 / GOOD_PTS, 5, points per perfect / good lane hit
- HP_MAX, 10 / MISS_DMG, 1, start HP / HP lost per miss unit
- OVER_CYCLES, 150_000_000, game-over hold time
- i_Clk  in  1  system clock (50 MHz)
- i_Rst  in  1  reset i_Rst, asynchronous, active-low
- i_Start  in  1  start pulse (1 cycle)
- i_Pause  in  1  pause level
- i_Hit  in  LANES  per-lane hit pulses, bit0 = lane 0
- i_Rand  in  LANES+4  random value; [3:0] density draw, [LANES+3:4] pattern
- i_Density  in  4  new row generated when i_Rand[3:0] < i_Density
- i_Speed_Opt  in  2  00 1x, 01 2x, 10 4x, 11 1x
- o_Map  out  ROWS*LANES  row r at bits [r*LANES +: LANES]; row 0 = judge row
- o_Score / o_High_Score  out  16  current / best score
- o_Combo / o_Max_Combo  out  8  current / best combo
- o_HP  out  $clog2(HP_MAX+1)  remaining HP
- o_State  out  2  0 IDLE, 1 PLAY, 2 PAUSE, 3 OVER
- o_Judge_Valid  out  1  judgement pulse
- o_Judge  out  2  1 perfect, 2 good, 3 miss

## Operation
- Reset values: state IDLE, map 0, score/high score/combo/max combo 0, HP = HP_MAX, period = BASE_PERIOD, tick counter 0, judge outputs 0. High score/max combo survive Start, not reset.
- IDLE: period <= BASE_PERIOD >> {0,1,2,0}[i_Speed_Opt] every cycle. i_Start: clear score, combo, map, counter; HP = HP_MAX; -> PLAY.
- PLAY, per cycle in order:
  - HP == 0: -> OVER, wait counter 0, high score <= max(high, score); hits ignored this cycle.
  - i_Pause: -> PAUSE; counter, map frozen; hits this cycle ignored.
  - Hit lane L with map[L] set: perfect if PERIOD/4 <= cnt < PERIOD - PERIOD/4, else good; clear map[L]. Hit lane with map[L] clear: ghost, one miss unit.
  - Tick when cnt == period-1: cnt <= 0; each note still in row 0 (after hit clearing) is one miss unit; map shifts down one row; top row = i_Rand pattern if i_Rand[3:0] < i_Density else 0. Otherwise cnt++.
  - Score += PERF_PTS·nPerf + GOOD_PTS·nGood, saturating at 0xFFFF.
  - Any miss unit in cycle: combo <= 0; else combo += nPerf+nGood, saturating at 255. Max combo <= max(max, new combo).
  - HP <= max(0, HP − MISS_DMG·nMiss).
  - nPerf+nGood >= 1: period <= max(PERIOD_MIN, period − PERIOD_STEP), once per cycle.
- PAUSE: all game state frozen; i_Pause low -> PLAY. i_Start ignored.
- OVER: count to OVER_CYCLES−1, then -> IDLE. i_Start, i_Hit ignored. Map held.
- Judge: any event in a PLAY cycle gives one pulse; priority miss > good > perfect.

## Timing
- All outputs registered; score/combo/HP/map update one clock after the event cycle; o_Judge_Valid high exactly one cycle, same cycle as score update.
- Scroll step every `period` clocks; period change applies from the next compare.
- Note entering top row reaches row 0 after ROWS−1 ticks, dropped (miss) on tick ROWS.
- Hit and tick in same cycle: hit judged against pre-shift row 0 first.
- Async reset mid-game: immediate return to reset values.

## Test plan
- Params LANES=4, ROWS=4, BASE_PERIOD=16, PERIOD_MIN=4, PERIOD_STEP=2, HP_MAX=3, OVER_CYCLES=20. Reset -> o_State 0, o_HP 3, o_Map 0, o_Score 0.
- Start, i_Density=15, i_Rand pattern 4'b0101 -> 16 clocks later o_Map[15:12]=0101; after 3 more ticks o_Map[3:0]=0101.
- Hit lanes 0 and 2 together at cnt=8 -> score +20, combo +2, single judge pulse code 1, period 14, o_Map[3:0]=0000.
- Hit lane 1 at cnt=2 with note present -> code 2, score +5; ghost hit lane 3 same cycle -> code 3, combo 0, HP −1.
- Let two notes drop at tick -> HP −2; with HP 2 -> HP 0, next cycle o_State 3, high score updated; 20 clocks later o_State 0.
- Assert i_Pause 10 cycles during PLAY -> o_State 2, map/counter unchanged, hits give no judge; release -> resumes same cnt.
